// File: rtl/rvv_backend_alu_rs_fifo.sv
// ALU reservation station: in-order multi-push / multi-pop FIFO between dispatch and the ALU stage.
// Flags are registered from next-cycle occupancy; read data is combinational from storage.
module rvv_backend_alu_rs_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned NUM_POP  = 2,
  parameter int unsigned UOP_W    = 64,
  parameter bit          EnAssert = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PUSH-1:0]              push_dp2rs,
  input  logic [NUM_PUSH-1:0][UOP_W-1:0]   uop_dp2rs,
  output logic                             fifo_full_rs2dp,
  output logic [NUM_PUSH-1:1]              fifo_almost_full_rs2dp,
  input  logic [NUM_POP-1:0]               pop_ex2rs,
  output logic [NUM_POP-1:0][UOP_W-1:0]    alu_uop_rs2ex,
  output logic                             fifo_empty_rs2ex,
  output logic [NUM_POP-1:1]               fifo_almost_empty_rs2ex,
  input  logic                             flush
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [DEPTH-1:0][UOP_W-1:0] mem_q;
  ptr_t                        wr_ptr_q, wr_ptr_d;
  ptr_t                        rd_ptr_q, rd_ptr_d;
  cnt_t                        count_q, count_d;

  logic [NUM_PUSH-1:0] push_run;
  cnt_t                n_push_req, n_push, free_space;
  cnt_t                n_pop_req, n_pop;

  logic                full_q, full_d;
  logic [NUM_PUSH-1:1] afull_q, afull_d;
  logic                empty_q, empty_d;
  logic [NUM_POP-1:1]  aempty_q, aempty_d;

  // Only the unbroken run of requests starting at lane 0 counts.
  always_comb begin
    logic run;
    run        = 1'b1;
    push_run   = '0;
    n_push_req = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      run         = run & push_dp2rs[i];
      push_run[i] = run;
      n_push_req  = n_push_req + cnt_t'(run);
    end
  end

  always_comb begin
    logic run;
    run       = 1'b1;
    n_pop_req = '0;
    for (int i = 0; i < NUM_POP; i++) begin
      run       = run & pop_ex2rs[i];
      n_pop_req = n_pop_req + cnt_t'(run);
    end
  end

  // Acceptance uses pre-cycle count only: no same-cycle room creation or bypass.
  always_comb begin
    free_space = cnt_t'(DEPTH) - count_q;
    n_push     = (n_push_req > free_space) ? free_space : n_push_req;
    n_pop      = (n_pop_req > count_q) ? count_q : n_pop_req;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ptr_t'(n_push);
      rd_ptr_d = rd_ptr_q + ptr_t'(n_pop);
      count_d  = count_q + n_push - n_pop;
    end
  end

  always_comb begin
    full_d  = (count_d == cnt_t'(DEPTH));
    empty_d = (count_d == '0);
    afull_d = '0;
    aempty_d = '0;
    for (int i = 1; i < NUM_PUSH; i++) begin
      afull_d[i] = (cnt_t'(DEPTH) - count_d) <= cnt_t'(i);
    end
    for (int i = 1; i < NUM_POP; i++) begin
      aempty_d[i] = count_d <= cnt_t'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= '1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (!flush) begin
      for (int i = 0; i < NUM_PUSH; i++) begin
        if (cnt_t'(i) < n_push) begin
          mem_q[wr_ptr_q + ptr_t'(i)] <= uop_dp2rs[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_POP; i++) begin
      alu_uop_rs2ex[i] = mem_q[rd_ptr_q + ptr_t'(i)];
    end
  end

  assign fifo_full_rs2dp         = full_q;
  assign fifo_almost_full_rs2dp  = afull_q;
  assign fifo_empty_rs2ex        = empty_q;
  assign fifo_almost_empty_rs2ex = aempty_q;

  // Non-contiguous pops are legal (ROB stall on lane 0); non-contiguous pushes are not.
  if (EnAssert) begin : g_assert
    assert property (@(posedge clk) disable iff (!rst_n || flush)
                     (push_dp2rs & ~push_run) == '0);
    assert property (@(posedge clk) disable iff (!rst_n || flush)
                     n_push_req <= free_space);
    assert property (@(posedge clk) disable iff (!rst_n || flush)
                     n_pop_req <= count_q);
  end

endmodule

// File: tb/tb_rvv_backend_alu_rs_fifo.sv
// Directed bench for the ALU reservation-station FIFO with a queue-based data scoreboard.
module tb_rvv_backend_alu_rs_fifo;

  localparam int unsigned W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        push_dp2rs = '0;
  logic [1:0][W-1:0] uop_dp2rs = '0;
  logic              fifo_full_rs2dp;
  logic [1:1]        fifo_almost_full_rs2dp;
  logic [1:0]        pop_ex2rs = '0;
  logic [1:0][W-1:0] alu_uop_rs2ex;
  logic              fifo_empty_rs2ex;
  logic [1:1]        fifo_almost_empty_rs2ex;
  logic              flush = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rvv_backend_alu_rs_fifo #(
    .DEPTH    (8),
    .NUM_PUSH (2),
    .NUM_POP  (2),
    .UOP_W    (W),
    .EnAssert (1'b0)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .push_dp2rs              (push_dp2rs),
    .uop_dp2rs               (uop_dp2rs),
    .fifo_full_rs2dp         (fifo_full_rs2dp),
    .fifo_almost_full_rs2dp  (fifo_almost_full_rs2dp),
    .pop_ex2rs               (pop_ex2rs),
    .alu_uop_rs2ex           (alu_uop_rs2ex),
    .fifo_empty_rs2ex        (fifo_empty_rs2ex),
    .fifo_almost_empty_rs2ex (fifo_almost_empty_rs2ex),
    .flush                   (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic e, input logic ae, input logic f,
                           input logic af);
    chk({name, ".empty"}, W'(fifo_empty_rs2ex), W'(e));
    chk({name, ".aempty"}, W'(fifo_almost_empty_rs2ex[1]), W'(ae));
    chk({name, ".full"}, W'(fifo_full_rs2dp), W'(f));
    chk({name, ".afull"}, W'(fifo_almost_full_rs2dp[1]), W'(af));
  endtask

  task automatic chk_data(input string name, input logic [W-1:0] d0, input logic [W-1:0] d1);
    chk({name, ".uop0"}, alu_uop_rs2ex[0], d0);
    chk({name, ".uop1"}, alu_uop_rs2ex[1], d1);
  endtask

  // acc = number of pushed lanes expected to be accepted (hand-determined per vector).
  task automatic step(input logic [1:0] push, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] pop, input logic fl, input int acc);
    push_dp2rs   = push;
    uop_dp2rs[0] = a;
    uop_dp2rs[1] = b;
    pop_ex2rs    = pop;
    flush        = fl;
    if (fl) exp_q.delete();
    if (acc >= 1) exp_q.push_back(a);
    if (acc >= 2) exp_q.push_back(b);
    @(posedge clk);
    #1;
    push_dp2rs = '0;
    uop_dp2rs  = '0;
    pop_ex2rs  = '0;
    flush      = 1'b0;
  endtask

  // Monitor: for each popped lane that holds an entry (by bench occupancy), compare oldest data.
  always @(negedge clk) begin : monitor
    bit run;
    int occ;
    run = 1'b1;
    if (rst_n && !flush) begin
      occ = exp_q.size();
      for (int i = 0; i < 2; i++) begin
        run = run && pop_ex2rs[i];
        if (run && i < occ) chk("sb_pop", alu_uop_rs2ex[i], exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_data("reset", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b11, 32'h0A, 32'h0B, 2'b00, 1'b0, 2);
    chk_flags("push2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_data("push2", 32'h0A, 32'h0B);
    step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("pop2", 1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      step(2'b11, 32'h10 + 2 * k, 32'h11 + 2 * k, 2'b00, 1'b0, 2);
      if (k == 2) chk_flags("fill6", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_flags("fill8", 1'b0, 1'b0, 1'b1, 1'b1);
    step(2'b01, 32'hEE, '0, 2'b00, 1'b0, 0);
    chk_flags("push_full", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_data("push_full", 32'h10, 32'h11);
    for (int k = 0; k < 4; k++) step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("drain8", 1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) step(2'b11, 32'h60 + 2 * k, 32'h61 + 2 * k, 2'b00, 1'b0, 2);
    step(2'b01, 32'h66, '0, 2'b00, 1'b0, 1);
    chk_flags("cnt7", 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'b11, 32'h67, 32'h68, 2'b00, 1'b0, 1);
    chk_flags("cnt7_push2", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("drain7", 1'b1, 1'b1, 1'b0, 1'b0);

    step(2'b11, 32'h100, 32'h101, 2'b00, 1'b0, 2);
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 32'h102 + 2 * k, 32'h103 + 2 * k, 2'b11, 1'b0, 2);
    end
    chk_flags("wrap", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_data("wrap", 32'h114, 32'h115);
    step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("wrap_drain", 1'b1, 1'b1, 1'b0, 1'b0);

    step(2'b11, 32'h20, 32'h21, 2'b00, 1'b0, 2);
    step(2'b01, 32'h22, '0, 2'b00, 1'b0, 1);
    step(2'b00, '0, '0, 2'b10, 1'b0, 0);
    chk_data("pop10", 32'h20, 32'h21);
    chk_flags("pop10", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, '0, '0, 2'b01, 1'b0, 0);
    chk_data("pop01", 32'h21, 32'h22);
    step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("nc_drain", 1'b1, 1'b1, 1'b0, 1'b0);

    step(2'b11, 32'h30, 32'h31, 2'b00, 1'b0, 2);
    step(2'b11, 32'h32, 32'h33, 2'b00, 1'b0, 2);
    step(2'b01, 32'h34, '0, 2'b00, 1'b0, 1);
    step(2'b11, 32'h35, 32'h36, 2'b11, 1'b1, 0);
    chk_flags("flush", 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'b11, 32'h50, 32'h51, 2'b00, 1'b0, 2);
    chk_data("post_flush", 32'h50, 32'h51);

    step(2'b11, 32'h40, 32'h41, 2'b00, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_flags("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_data("mid_reset", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 32'h70, 32'h71, 2'b00, 1'b0, 2);
    chk_data("post_reset", 32'h70, 32'h71);
    step(2'b00, '0, '0, 2'b11, 1'b0, 0);
    chk_flags("final", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sb_left", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvv_backend_alu_rs_fifo.md
# rvv_backend_alu_rs_fifo

ALU reservation station for the RVV backend: an in-order, multi-push/multi-pop FIFO that buffers ALU uops from dispatch. It feeds the ALU execution stage, presenting the oldest `NUM_POP` entries in parallel with empty and almost-empty flags. The ALU stage turns those flags into per-unit valids and returns a per-lane pop vector once the ROB accepts each result.

## Interface
- `DEPTH`, 8: number of entries; power of 2, must be greater than both `NUM_PUSH` and `NUM_POP`.
- `NUM_PUSH`, 2: dispatch push lanes.
- `NUM_POP`, 2: ALU pop lanes; equals `NUM_ALU`.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `push_dp2rs`  in  NUM_PUSH: per-lane push request.
- `uop_dp2rs`  in  NUM_PUSH x ALU_RS_t: push data.
- `fifo_full_rs2dp`  out  1: registered; count == DEPTH.
- `fifo_almost_full_rs2dp`  out  [NUM_PUSH-1:1]: bit i = (DEPTH − count) <= i.
- `pop_ex2rs`  in  NUM_POP: per-lane pop from the ALU stage.
- `alu_uop_rs2ex`  out  NUM_POP x ALU_RS_t: entry at rd_ptr+i, modulo DEPTH.
- `fifo_empty_rs2ex`  out  1: count == 0.
- `fifo_almost_empty_rs2ex`  out  [NUM_POP-1:1]: bit i = count <= i.
- `flush`  in  1: synchronous clear.

## Operation
- State:
  - storage array `DEPTH` x ALU_RS_t.
  - `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- Push acceptance:
  - n_push = number of leading ones of `push_dp2rs` starting at lane 0, capped at the pre-cycle free space (DEPTH − count).
  - Lane i is written to wr_ptr+i.
  - A push on a lane above a 0 lane is ignored (assertion error).
  - Pushes beyond the free space are dropped (assertion error). Dispatch must use the full/almost_full flags to avoid this.
- Pop acceptance:
  - n_pop = number of leading ones of `pop_ex2rs`, capped at the pre-cycle count.
  - Non-contiguous pop bits (e.g. 2'b10) are ignored above the first 0 and do not raise an error, because the ALU stage legitimately produces them when the ROB stalls lane 0.
  - Popping beyond count raises an assertion error.
- Update, per cycle:
  - wr_ptr += n_push
  - rd_ptr += n_pop
  - count += n_push − n_pop
- Simultaneous push and pop:
  - Free space and occupancy for acceptance are computed from pre-cycle `count` only.
  - A pop does not create room for a same-cycle push.
  - A push is not visible to a same-cycle pop (no bypass).
- Flags: registered, computed from next-cycle `count`, so they are consistent with `count` every cycle.
- Read data: combinational from storage at rd_ptr+i. Contents are stale when count <= i; consumers must qualify with the flags.
- Flush: rd_ptr, wr_ptr and count go to 0 next cycle, and flags go to the empty state. Push and pop in the flush cycle are discarded. Storage is not cleared.
- Reset (async on `rst_n` low):
  - pointers and count = 0, storage = 0
  - `fifo_empty_rs2ex` = 1, `fifo_almost_empty_rs2ex` = all 1
  - `fifo_full_rs2dp` = 0, `fifo_almost_full_rs2dp` = all 0
  - `alu_uop_rs2ex` = all 0

## Timing
- Push to output visibility: 1 cycle. An entry pushed in cycle N appears on `alu_uop_rs2ex` and is reflected in the flags in cycle N+1.
- Pop to advance: rd_ptr moves at the clock edge; the next entries appear in cycle N+1.
- Flag updates: `fifo_full_rs2dp` and the almost-full flags update 1 cycle after the push/pop that changes count.
- Throughput: up to NUM_PUSH pushes and NUM_POP pops per cycle, sustained.
- Reset mid-operation: the FIFO empties immediately (async). The first push after `rst_n` rises is accepted in the first rising edge.

## Test plan
- Reset, then push lanes 2'b11 with A,B in cycle 0:
  - cycle 1: count=2, empty=0, almost_empty[1]=0
  - outputs {B,A}
  - pop 2'b11: cycle 2 is empty.
- Fill to DEPTH=8 with 4 double-pushes:
  - full=1 after the 4th push.
  - A further push 2'b01 while full is dropped; count stays 8; assertion fires.
- count=7:
  - almost_full[1]=1
  - push 2'b11 with pop 2'b00: only lane 0 is accepted, count=8.
- Wrap-around:
  - Push and pop 2 per cycle for 10 cycles.
  - Pointers wrap, data order is preserved, count stays 2.
- Non-contiguous pop:
  - count=3 with entries A,B,C; pop 2'b10.
  - Nothing is popped, outputs stay {B,A}, no error.
  - Then pop 2'b01: outputs become {C,B}.
- `flush` with count=5 plus a simultaneous push/pop:
  - Next cycle count=0, empty=1, almost_empty all 1.
  - `rst_n` pulsed low mid-stream gives the same flag values, with outputs 0.
